// File: rtl/tx_symbol_nco.sv
// Transmit symbol-timing NCO: a 16-bit phase accumulator whose carry marks symbol
// boundaries. On each boundary it pulls one symbol upstream, or inserts IDLE_SYM on underflow.
module tx_symbol_nco #(
  parameter int              SW         = 4,
  parameter logic [15:0]     PHASE_INIT = 16'h0000,
  parameter logic [SW-1:0]   IDLE_SYM   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [15:0]   fcw,
  input  logic          sym_valid,
  input  logic [SW-1:0] sym_data,
  output logic          sym_ready,
  input  logic          clr_cnt,
  output logic [SW-1:0] sym_out,
  output logic          strobe,
  output logic [15:0]   mu,
  output logic          underflow,
  output logic [7:0]    uf_cnt
);

  logic [15:0]   phase_q, phase_d;
  logic [SW-1:0] sym_q, sym_d;
  logic          strobe_q, strobe_d;
  logic          uf_q, uf_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [16:0]   sum;
  logic          bnd;

  assign sum = {1'b0, phase_q} + {1'b0, fcw};
  assign bnd = en & sum[16];

  // Ready is the look-ahead of the boundary on the coming edge, so upstream
  // sees it in the same cycle the symbol will be latched.
  assign sym_ready = bnd & ~rst;

  always_comb begin
    phase_d  = phase_q;
    sym_d    = sym_q;
    strobe_d = 1'b0;
    uf_d     = 1'b0;
    cnt_d    = cnt_q;
    if (en) begin
      phase_d  = sum[15:0];
      strobe_d = sum[16];
      if (sum[16]) begin
        if (sym_valid) begin
          sym_d = sym_data;
        end else begin
          sym_d = IDLE_SYM;
          uf_d  = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
    end
    if (clr_cnt) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PHASE_INIT;
      sym_q    <= IDLE_SYM;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      phase_q  <= phase_d;
      sym_q    <= sym_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sym_out   = sym_q;
  assign strobe    = strobe_q;
  assign mu        = phase_q;
  assign underflow = uf_q;
  assign uf_cnt    = cnt_q;

endmodule

// File: tb/tb_tx_symbol_nco.sv
// Directed bench for tx_symbol_nco: an integer-arithmetic reference model checked
// every cycle, plus hand-computed expectations along each directed scenario.
module tb_tx_symbol_nco;
  localparam logic [3:0] IDLE = 4'h0;

  logic        clk = 1'b0;
  logic        rst, en, sym_valid, clr_cnt;
  logic [15:0] fcw;
  logic [3:0]  sym_data;
  logic        sym_ready, strobe, underflow;
  logic [3:0]  sym_out;
  logic [15:0] mu;
  logic [7:0]  uf_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_symbol_nco #(.SW(4), .PHASE_INIT(16'h0000), .IDLE_SYM(IDLE)) dut (
    .clk(clk), .rst(rst), .en(en), .fcw(fcw), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(sym_ready), .clr_cnt(clr_cnt),
    .sym_out(sym_out), .strobe(strobe), .mu(mu), .underflow(underflow),
    .uf_cnt(uf_cnt)
  );

  // Reference model: phase as a plain integer, boundary when it reaches one period.
  int         m_phase;
  logic [3:0] m_sym;
  logic       m_stb, m_uf;
  int         m_cnt;

  function automatic bit m_rdy();
    return (rst === 1'b0) && (en === 1'b1) && ((m_phase + int'(fcw)) >= 65536);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_sym   <= IDLE;
      m_stb   <= 1'b0;
      m_uf    <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_stb <= 1'b0;
      m_uf  <= 1'b0;
      if (en) begin
        m_phase <= (m_phase + int'(fcw)) % 65536;
        if ((m_phase + int'(fcw)) >= 65536) begin
          m_stb <= 1'b1;
          if (sym_valid) m_sym <= sym_data;
          else begin
            m_sym <= IDLE;
            m_uf  <= 1'b1;
            if (!clr_cnt) m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
          end
        end
      end
      if (clr_cnt) m_cnt <= 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cyc_sym_out", sym_out, m_sym);
      chk("cyc_strobe", strobe, m_stb);
      chk("cyc_underflow", underflow, m_uf);
      chk("cyc_mu", mu, m_phase);
      chk("cyc_uf_cnt", uf_cnt, m_cnt);
      chk("cyc_sym_ready", sym_ready, m_rdy());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One edge; upstream steps its data after every transfer.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit r;
      r = m_rdy();
      tick();
      if (r && sym_valid) sym_data = sym_data + 4'd1;
    end
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 16; i++) begin
      if (m_rdy()) break;
      run(1);
    end
    chk("wait_rdy_timeout", m_rdy(), 1);
  endtask

  initial begin
    logic [3:0]  d;
    logic [15:0] pmu;
    int last, nstb, nuf;
    rst = 1'b1; en = 1'b0; fcw = 16'h0; sym_valid = 1'b0; sym_data = 4'h0; clr_cnt = 1'b0;
    tick(); tick();
    chk("rst_sym_out", sym_out, IDLE);
    chk("rst_strobe", strobe, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_uf_cnt", uf_cnt, 0);
    chk("rst_mu", mu, 0);
    chk("rst_ready", sym_ready, 0);

    // Quarter-rate stream, data 1,2,3
    rst = 1'b0; en = 1'b1; fcw = 16'h4000; sym_valid = 1'b1; sym_data = 4'h1;
    for (int i = 1; i <= 12; i++) begin
      run(1);
      if (i == 1) chk("q_mu1", mu, 16'h4000);
      if (i == 2) chk("q_mu2", mu, 16'h8000);
      if (i == 3) begin chk("q_mu3", mu, 16'hC000); chk("q_ready3", sym_ready, 1); chk("q_stb3", strobe, 0); end
      if (i == 4) begin chk("q_stb4", strobe, 1); chk("q_sym4", sym_out, 1); chk("q_mu4", mu, 0); end
      if (i == 8) chk("q_sym8", sym_out, 2);
      if (i == 12) begin chk("q_sym12", sym_out, 3); chk("q_uf12", underflow, 0); end
    end

    // One starved boundary then resume
    wait_rdy();
    sym_valid = 1'b0;
    run(1);
    chk("u_underflow", underflow, 1);
    chk("u_sym", sym_out, IDLE);
    chk("u_cnt", uf_cnt, 1);
    chk("u_strobe", strobe, 1);
    sym_valid = 1'b1;
    run(4);
    chk("u_resume_sym", sym_out, 4);
    chk("u_resume_uf", underflow, 0);
    chk("u_resume_cnt", uf_cnt, 1);

    // fcw=5555 from phase 0: first strobe at edge 4, mu 5554, then -1 per symbol
    fcw = 16'h5555;
    last = -1; nstb = 0; pmu = 16'h0;
    for (int i = 1; i <= 300; i++) begin
      run(1);
      if (strobe === 1'b1) begin
        if (last < 0) begin
          chk("f_first_cyc", i, 4);
          chk("f_first_mu", mu, 16'h5554);
        end else begin
          chk("f_interval", i - last, (pmu != 0) ? 3 : 4);
          chk("f_mu_step", mu, (pmu != 0) ? pmu - 16'd1 : 16'h5554);
        end
        last = i; pmu = mu; nstb++;
      end
    end
    checks++;
    if (nstb < 99 || nstb > 101) begin
      failures++;
      $display("FAIL f_rate actual=%0d required=99..101", nstb);
    end

    // Reset pulse between edges with a symbol pending
    fcw = 16'h4000; sym_valid = 1'b1;
    wait_rdy();
    d = sym_data;
    rst = 1'b1;
    #1;
    chk("r_sym", sym_out, IDLE);
    chk("r_strobe", strobe, 0);
    chk("r_underflow", underflow, 0);
    chk("r_mu", mu, 0);
    chk("r_cnt", uf_cnt, 0);
    chk("r_ready", sym_ready, 0);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      run(1);
      if (i < 4) chk("r_nostb", strobe, 0);
      else begin chk("r_stb4", strobe, 1); chk("r_pending", sym_out, d); chk("r_mu4", mu, 0); end
    end

    // Enable gap of 5 cycles mid-symbol
    run(2);
    chk("e_mu_pre", mu, 16'h8000);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run(1);
      chk("e_mu_hold", mu, 16'h8000);
      chk("e_sym_hold", sym_out, d);
      chk("e_stb", strobe, 0);
      chk("e_ready", sym_ready, 0);
    end
    en = 1'b1;
    run(1);
    chk("e_mu_res", mu, 16'hC000);
    chk("e_stb_res", strobe, 0);
    run(1);
    chk("e_stb_bnd", strobe, 1);
    chk("e_sym_bnd", sym_out, d + 4'd1);

    // Saturating underflow count, then clear against a simultaneous underflow
    sym_valid = 1'b0; fcw = 16'hFFFF;
    run(1);  // phase 0 -> FFFF, no boundary
    nuf = 0;
    for (int i = 0; i < 309; i++) begin
      run(1);
      if (underflow === 1'b1) nuf++;
    end
    chk("s_uf_pulses", nuf, 309);
    chk("s_sat", uf_cnt, 255);
    wait_rdy();
    clr_cnt = 1'b1;
    run(1);
    chk("c_cnt", uf_cnt, 0);
    chk("c_uf", underflow, 1);
    clr_cnt = 1'b0;
    run(1);
    chk("c_after", uf_cnt, 1);

    // fcw=0 never reaches a boundary
    fcw = 16'h0;
    nstb = 0;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (strobe === 1'b1) nstb++;
    end
    chk("z_strobes", nstb, 0);
    chk("z_cnt", uf_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_symbol_nco.md
TX_SYMBOL_NCO -- requirements
Module: tx_symbol_nco

Interface
REQ-001 Parameter SW, default 4: symbol width in bits (QAM16 symbol index).
REQ-002 Parameter PHASE_INIT, default 16'h0000: phase register value at reset.
REQ-003 Parameter IDLE_SYM, default 4'b0000: symbol inserted on underflow.
REQ-004 clk  in  1: single clock, sample rate (4x symbol rate nominal); all logic on rising edge.
REQ-005 rst  in  1: asynchronous reset, active-high.
REQ-006 en  in  1: advance enable; 0 freezes the block.
REQ-007 fcw  in  16: unsigned phase step per clock, Q0.16 fraction of one symbol period.
REQ-008 sym_valid  in  1: upstream symbol available.
REQ-009 sym_data  in  SW: upstream symbol.
REQ-010 sym_ready  out  1: combinational accept signal; a transfer occurs when sym_valid and sym_ready are both 1 on a rising edge.
REQ-011 clr_cnt  in  1: synchronous clear of the underflow counter.
REQ-012 sym_out  out  SW: registered current transmit symbol.
REQ-013 strobe  out  1: registered one-cycle pulse; sym_out changed this cycle.
REQ-014 mu  out  16: registered phase register, Q0.16 fractional position past the last symbol boundary, for the transmit interpolator.
REQ-015 underflow  out  1: registered one-cycle pulse; IDLE_SYM was inserted.
REQ-016 uf_cnt  out  8: saturating underflow count.

Function
REQ-017 Each edge with en=1: the 17-bit sum {c,p} = phase + fcw SHALL be formed, and phase <= p (mod 2^16).
REQ-018 c=1 SHALL mark a symbol boundary; strobe <= c.
REQ-019 sym_ready SHALL equal en AND (phase + fcw >= 2^16), from current phase and fcw; no registered ready.
REQ-020 At a boundary with sym_valid=1: sym_out <= sym_data; underflow <= 0.
REQ-021 At a boundary with sym_valid=0: sym_out <= IDLE_SYM; underflow <= 1; uf_cnt increments.
REQ-022 No boundary: sym_out holds; strobe and underflow <= 0; sym_valid ignored, no transfer.
REQ-023 Latency: symbol accepted on edge N appears on sym_out, with strobe=1, in the cycle after edge N.
REQ-024 mu SHALL equal the phase register; at a boundary it is the residual (phase + fcw - 2^16).
REQ-025 en=0: phase, sym_out, uf_cnt hold; strobe and underflow <= 0; sym_ready=0.
REQ-026 fcw=0: no boundary ever; block idles, no underflow counted.
REQ-027 fcw changes take effect on the same edge; no pipeline on fcw.
REQ-028 fcw >= 16'h8000: a boundary may occur on consecutive edges, each handled by REQ-020/021 independently.
REQ-029 uf_cnt SHALL saturate at 255.
REQ-030 clr_cnt=1 SHALL set uf_cnt to 0 on that edge; clear wins over a simultaneous underflow increment.
REQ-031 sym_data SHALL be captured only on transfer; no other path writes sym_out except IDLE_SYM and reset.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, set phase=PHASE_INIT, sym_out=IDLE_SYM, strobe=0, underflow=0, uf_cnt=0.
REQ-033 sym_ready SHALL be 0 while rst=1.
REQ-034 Reset asserted mid-operation SHALL discard the phase and held symbol; a symbol presented during reset is not accepted.
REQ-035 After rst deasserts, first boundary SHALL occur per REQ-017 from PHASE_INIT.

Verification
REQ-036 fcw=16'h4000, en=1, sym_valid=1 held, data 1,2,3...: sym_ready high every 4th cycle (when phase=16'hC000); strobe every 4 cycles; sym_out steps 1,2,3; mu cycles 4000,8000,C000,0000; underflow never.
REQ-037 fcw=16'h4000, sym_valid=0 at one boundary: sym_out=IDLE_SYM, underflow pulse, uf_cnt=1; next boundary with valid resumes data.
REQ-038 fcw=16'h5555: strobe intervals 3,3,3... cycles with mu residual decreasing by 1 per symbol; long-run average strobe rate = fcw/65536 within 1 strobe.
REQ-039 en toggled low for 5 cycles mid-symbol: phase, mu, sym_out frozen; sym_ready=0; schedule resumes shifted by exactly 5 cycles.
REQ-040 300 forced underflows: uf_cnt saturates at 255; clr_cnt coincident with an underflow -> uf_cnt=0.
REQ-041 rst pulsed between clock edges mid-stream: outputs at reset values immediately; pending symbol not consumed; first boundary after release at edge 4 with PHASE_INIT=0, fcw=16'h4000.
